// File: rtl/alu_writeback.sv
// ALU result write-back stage: captures one ALU result per accept and emits one or two
// register-file writes; optional forwarding outputs are enabled by ALU_WB_BYPASS_EN.
module alu_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] result1,
    input  logic              zFlag,
    input  logic              carryFlag,
    input  logic              signFlag,
    input  logic              overflowFlag,
    input  logic [ADDR_W-1:0] dest0,
    input  logic [ADDR_W-1:0] dest1,
    input  logic              dual,
    input  logic              flags_we,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_s,
    output logic              flag_v,
`ifdef ALU_WB_BYPASS_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] res0_q, res0_d;
    logic [DATA_W-1:0] res1_q, res1_d;
    logic [ADDR_W-1:0] dest0_q, dest0_d;
    logic [ADDR_W-1:0] dest1_q, dest1_d;
    logic              dual_q, dual_d;
    logic [3:0]        flags_q, flags_d;   // {z, c, s, v}
    logic              accept;

    // A dual transfer still owes its WR1 cycle, so WR0 can only overlap a new
    // accept when the captured transfer is single.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            WR0:     in_ready = !dual_q;
            WR1:     in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // NOTE: every signal gets its default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        dest0_d = dest0_q;
        dest1_d = dest1_q;
        dual_d  = dual_q;
        flags_d = flags_q;

        unique case (state_q)
            IDLE:    state_d = accept ? WR0 : IDLE;
            WR0:     state_d = dual_q ? WR1 : (accept ? WR0 : IDLE);
            WR1:     state_d = accept ? WR0 : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            res0_d  = result;
            res1_d  = result1;
            dest0_d = dest0;
            dest1_d = dest1;
            dual_d  = dual;
            if (flags_we) begin
                flags_d = {zFlag, carryFlag, signFlag, overflowFlag};
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order or process scheduling.
    // The captured data registers are reset as well: the write port exposes them
    // combinationally, and a clean zero keeps X out of the downstream register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res0_q  <= '0;
            res1_q  <= '0;
            dest0_q <= '0;
            dest1_q <= '0;
            dual_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            dest0_q <= dest0_d;
            dest1_q <= dest1_d;
            dual_q  <= dual_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        rf_waddr = '0;
        rf_wdata = '0;
        unique case (state_q)
            WR0: begin
                rf_waddr = dest0_q;
                rf_wdata = res0_q;
            end
            WR1: begin
                rf_waddr = dest1_q;
                rf_wdata = res1_q;
            end
            default: begin
                rf_waddr = '0;
                rf_wdata = '0;
            end
        endcase
    end

    // r0 is hard-wired zero: the slot is still consumed, only the strobe drops.
    assign busy  = (state_q != IDLE);
    assign rf_we = busy && (rf_waddr != '0);

    assign flag_z = flags_q[3];
    assign flag_c = flags_q[2];
    assign flag_s = flags_q[1];
    assign flag_v = flags_q[0];

`ifdef ALU_WB_BYPASS_EN
    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios with literal expectations,
// then randomized traffic against a queue-based model of pending register writes.
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic [31:0] result1;
    logic        zFlag, carryFlag, signFlag, overflowFlag;
    logic [4:0]  dest0, dest1;
    logic        dual;
    logic        flags_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flag_z, flag_c, flag_s, flag_v;
    logic        busy;
`ifdef ALU_WB_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    alu_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .result       (result),
        .result1      (result1),
        .zFlag        (zFlag),
        .carryFlag    (carryFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag),
        .dest0        (dest0),
        .dest1        (dest1),
        .dual         (dual),
        .flags_we     (flags_we),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_s       (flag_s),
        .flag_v       (flag_v),
`ifdef ALU_WB_BYPASS_EN
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted transfer becomes one or two pending writes, one per cycle.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [3:0] m_flags = 4'b0;

    always @(posedge clk) begin : model_update
        bit acc;
        if (rst_n !== 1'b1) begin
            wq.delete();
            m_flags = 4'b0;
        end else begin
            acc = in_valid && (wq.size() <= 1);
            if (wq.size() > 0) void'(wq.pop_front());
            if (acc) begin
                wq.push_back('{addr: dest0, data: result});
                if (dual) wq.push_back('{addr: dest1, data: result1});
                if (flags_we) m_flags = {zFlag, carryFlag, signFlag, overflowFlag};
            end
        end
    end

    always @(negedge clk) begin : model_compare
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        ew, eb;
        if (rst_n === 1'b1) begin
            if (wq.size() == 0) begin
                ea = 5'd0; ed = 32'd0; ew = 1'b0; eb = 1'b0;
            end else begin
                ea = wq[0].addr; ed = wq[0].data; ew = (ea != 5'd0); eb = 1'b1;
            end
            check("m_in_ready", 64'(in_ready), 64'(wq.size() <= 1));
            check("m_busy",     64'(busy),     64'(eb));
            check("m_rf_we",    64'(rf_we),    64'(ew));
            check("m_rf_waddr", 64'(rf_waddr), 64'(ea));
            check("m_rf_wdata", 64'(rf_wdata), 64'(ed));
            check("m_flags",    64'({flag_z, flag_c, flag_s, flag_v}), 64'(m_flags));
`ifdef ALU_WB_BYPASS_EN
            check("m_fwd", 64'({fwd_valid, fwd_addr, fwd_data}), 64'({ew, ea, ed}));
`endif
        end
    end

    // Presents a transfer and waits for its accept; returns at the cycle whose write
    // port shows that transfer, with in_valid left high.
    task automatic send(input logic [31:0] r, input logic [31:0] r1,
                        input logic [4:0] d0, input logic [4:0] d1,
                        input logic dl, input logic fwe, input logic [3:0] fl,
                        output int waits);
        bit done = 1'b0;
        bit rdy;
        result = r; result1 = r1; dest0 = d0; dest1 = d1; dual = dl; flags_we = fwe;
        {zFlag, carryFlag, signFlag, overflowFlag} = fl;
        in_valid = 1'b1;
        waits = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else waits++;
            @(negedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept expected=accept_within_20 t=%0t", $time);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        rst_n = 1'b0;
        in_valid = 1'b0; result = '0; result1 = '0; dest0 = '0; dest1 = '0;
        dual = 1'b0; flags_we = 1'b0;
        {zFlag, carryFlag, signFlag, overflowFlag} = 4'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        next_cycle();

        check("reset_rf_we",    64'(rf_we), 64'd0);
        check("reset_busy",     64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_addr",     64'(rf_waddr), 64'd0);
        check("reset_data",     64'(rf_wdata), 64'd0);
        check("reset_flags",    64'({flag_z, flag_c, flag_s, flag_v}), 64'd0);

        // Single write with carry flag.
        send(32'h0004_05E9, 32'h0, 5'd3, 5'd0, 1'b0, 1'b1, 4'b0100, w);
        check("single_we",   64'(rf_we), 64'd1);
        check("single_addr", 64'(rf_waddr), 64'd3);
        check("single_data", 64'(rf_wdata), 64'h0004_05E9);
        check("single_flag_c", 64'(flag_c), 64'd1);
`ifdef ALU_WB_BYPASS_EN
        check("single_fwd", 64'({fwd_valid, fwd_addr, fwd_data}), {31'd0, 1'b1, 5'd3, 32'h0004_05E9});
`endif
        in_valid = 1'b0;
        next_cycle();
        check("single_idle_busy", 64'(busy), 64'd0);
        check("single_flag_hold", 64'(flag_c), 64'd1);

        // Dual write; flags untouched since flags_we=0.
        send(32'h1234_5678, 32'h0000_ABCD, 5'd4, 5'd5, 1'b1, 1'b0, 4'b1111, w);
        in_valid = 1'b0;
        check("dual_wr0_addr",  64'(rf_waddr), 64'd4);
        check("dual_wr0_data",  64'(rf_wdata), 64'h1234_5678);
        check("dual_wr0_ready", 64'(in_ready), 64'd0);
        next_cycle();
        check("dual_wr1_we",    64'(rf_we), 64'd1);
        check("dual_wr1_addr",  64'(rf_waddr), 64'd5);
        check("dual_wr1_data",  64'(rf_wdata), 64'h0000_ABCD);
        check("dual_flags_hold", 64'({flag_z, flag_c, flag_s, flag_v}), 64'b0100);
        next_cycle();
        check("dual_done_busy", 64'(busy), 64'd0);

        // Back-to-back singles with no bubble.
        for (int k = 1; k <= 3; k++) begin
            send(32'hA000_0000 + 32'(k), 32'h0, 5'(k), 5'd0, 1'b0, 1'b0, 4'b0, w);
            check("b2b_waits", 64'(w), 64'd0);
            check("b2b_we",    64'(rf_we), 64'd1);
            check("b2b_addr",  64'(rf_waddr), 64'(k));
        end
        in_valid = 1'b0;
        next_cycle();

        // Write to r0 consumes a cycle without a strobe.
        send(32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0, w);
        in_valid = 1'b0;
        check("r0_busy", 64'(busy), 64'd1);
        check("r0_we",   64'(rf_we), 64'd0);
        next_cycle();
        check("r0_after_busy", 64'(busy), 64'd0);

        // Same destination twice: result1 lands last.
        send(32'h0000_1111, 32'h0000_2222, 5'd9, 5'd9, 1'b1, 1'b0, 4'b0, w);
        in_valid = 1'b0;
        check("same_dest_first",  64'(rf_wdata), 64'h0000_1111);
        next_cycle();
        check("same_dest_second", 64'(rf_wdata), 64'h0000_2222);
        check("same_dest_addr",   64'(rf_waddr), 64'd9);
        next_cycle();

        // Reset in the middle of a dual transfer.
        send(32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd6, 5'd7, 1'b1, 1'b1, 4'b1111, w);
        in_valid = 1'b0;
        check("rst_pre_we",     64'(rf_we), 64'd1);
        check("rst_pre_flag_z", 64'(flag_z), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_we",    64'(rf_we), 64'd0);
        check("rst_async_busy",  64'(busy), 64'd0);
        check("rst_async_addr",  64'(rf_waddr), 64'd0);
        check("rst_async_data",  64'(rf_wdata), 64'd0);
        check("rst_async_flags", 64'({flag_z, flag_c, flag_s, flag_v}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check("rst_no_wr1_we",   64'(rf_we), 64'd0);
            check("rst_no_wr1_busy", 64'(busy), 64'd0);
        end

        // Randomized traffic; inputs may change while stalled and must be ignored.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end else begin
                in_valid = ($urandom_range(0, 9) < 7);
                result   = $urandom;
                result1  = $urandom;
                dest0    = 5'($urandom_range(0, 7));
                dest1    = 5'($urandom_range(0, 7));
                dual     = 1'($urandom_range(0, 1));
                flags_we = 1'($urandom_range(0, 1));
                {zFlag, carryFlag, signFlag, overflowFlag} = 4'($urandom_range(0, 15));
                next_cycle();
            end
        end
        in_valid = 1'b0;
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the result, result1 and write-data paths.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the width of the register-file address.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an ALU result is presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the presented result this cycle.
REQ-007 The block SHALL have ports result and result1, inputs, DATA_W each, meaning ALU primary and secondary results.
REQ-008 The block SHALL have ports zFlag, carryFlag, signFlag and overflowFlag, inputs, 1 each, meaning the ALU flags.
REQ-009 The block SHALL have ports dest0 and dest1, inputs, ADDR_W each, meaning the destinations for result and result1.
REQ-010 The block SHALL have port dual, input, 1, meaning result1 is also written.
REQ-011 The block SHALL have port flags_we, input, 1, meaning the flag register updates on accept.
REQ-012 The block SHALL have ports rf_we (1), rf_waddr (ADDR_W) and rf_wdata (DATA_W), outputs, forming the register-file write port.
REQ-013 The block SHALL have ports flag_z, flag_c, flag_s and flag_v, outputs, 1 each, meaning the architectural flag register.
REQ-014 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, WR0 and WR1.
REQ-016 Accept SHALL be defined as in_valid and in_ready high at a rising edge; on accept, result, result1, dest0, dest1 and dual are captured and the next state is WR0.
REQ-017 in_ready SHALL be combinational: high in IDLE, in WR0 when captured dual is 0, and in WR1; low otherwise.
REQ-018 In WR0 the block SHALL drive rf_waddr=dest0 and rf_wdata=result (captured values), and next state SHALL be WR1 if dual, else WR0 on accept, else IDLE.
REQ-019 In WR1 the block SHALL drive rf_waddr=dest1 and rf_wdata=result1, and next state SHALL be WR0 on accept, else IDLE.
REQ-020 rf_we SHALL be high in WR0 and WR1 except when the driven rf_waddr is 0, in which case it is low while the state still consumes its cycle.
REQ-021 Latency SHALL be one cycle: data accepted at edge N appears on the write port during cycle N to N+1; throughput is 1 per cycle single and 1 per 2 cycles dual.
REQ-022 In IDLE, rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL be 0.
REQ-023 Flags SHALL load the four input flags at an accept edge with flags_we=1 and hold otherwise, including during WR0, WR1 and non-accepted cycles.
REQ-024 dest0 equal to dest1 with dual SHALL cause two writes in order, so that result1 is the final value.
REQ-025 in_valid high while in_ready is low SHALL NOT alter any state; the upstream holds its inputs.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state to IDLE, rf_we to 0, and rf_waddr, rf_wdata and all flag outputs to 0, including mid-WR0 or mid-WR1.
REQ-027 A dual transfer interrupted by reset SHALL be discarded; no write of result1 occurs after release.
REQ-028 After rst_n deasserts, in_ready SHALL be high in the first cycle.

Configuration
REQ-029 With macro ALU_WB_BYPASS_EN defined, the block SHALL add outputs fwd_valid (1), fwd_addr (ADDR_W) and fwd_data (DATA_W), combinationally equal to rf_we, rf_waddr and rf_wdata, for operand forwarding upstream.
REQ-030 Without ALU_WB_BYPASS_EN, those ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Single write: result=0x000405E9, carryFlag=1, dest0=3, dual=0, flags_we=1, accept -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x000405E9, flag_c=1 from that cycle.
REQ-032 Dual write: result=0x12345678, result1=0x0000ABCD, dest0=4, dest1=5 -> WR0 writes 0x12345678 to reg 4, then WR1 writes 0x0000ABCD to reg 5; in_ready is low during WR0.
REQ-033 Back-to-back: in_valid held high with dest0=1, 2, 3 on consecutive edges -> three consecutive cycles of rf_we=1 to registers 1, 2, 3 with no bubble.
REQ-034 r0 suppression: dest0=0, result=0xFFFFFFFF -> busy=1 for one cycle, rf_we stays 0.
REQ-035 Reset mid-dual: rst_n driven low during WR0 -> rf_we=0 and flags=0 asynchronously; after release, no write of result1 occurs and in_ready=1.
REQ-036 With ALU_WB_BYPASS_EN, in the REQ-031 stimulus -> fwd_valid=1, fwd_addr=3, fwd_data=0x000405E9 in the same cycle as the write.
